// File: rtl/flash_cmd_pkg.sv
// ============================================================================
//  Module      : flash_cmd_pkg
//  Description : SPI flash opcodes, status bit index and sequencer state
//                encoding shared by the page programmer.
//                FLASH_PROG_ERASE_EN adds the erase-phase states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_cmd_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PE   = 8'h81;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  // Write-in-progress bit of the status register
  localparam int WIP_BIT = 0;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
`ifdef FLASH_PROG_ERASE_EN
    S_WREN_A  = 4'd1,
    S_PE      = 4'd2,
    S_POLL_E  = 4'd3,
`endif
    S_WREN_B  = 4'd4,
    S_PP_WAIT = 4'd5,
    S_PP      = 4'd6,
    S_POLL_P  = 4'd7,
    S_GAP     = 4'd8,
    S_DONE    = 4'd9
  } prog_state_t;

endpackage

`default_nettype wire

// File: rtl/flash_page_buffer.sv
// ============================================================================
//  Module      : flash_page_buffer
//  Description : 256 x 8 simple dual-port page buffer, one write port and one
//                synchronous read port (1-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_page_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:255];

  // Write port: storage array has no reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered output so the consumer sees a clean reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= 8'h00;
    else     rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/flash_page_programmer.sv
// ============================================================================
//  Module      : flash_page_programmer
//  Description : Loads one page into a local buffer and programs it through
//                the SPI flash interface: WREN, [PE, RDSR poll], WREN, PP,
//                RDSR poll. Build macro FLASH_PROG_ERASE_EN enables the
//                page-erase phase.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_page_programmer
  import flash_cmd_pkg::*;
#(
  parameter int CS_HIGH_CYCLES = 4,
  parameter int MAX_POLLS      = 65535
) (
  input  logic        serialClk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] startAddr,
  input  logic [8:0]  startLen,
  input  logic [7:0]  wrData,
  input  logic        wrValid,
  output logic        wrReady,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        interfaceEnable_n,
  output logic [7:0]  fCommand,
  output logic [23:0] fAddress,
  output logic [7:0]  fData_WR,
  input  logic [7:0]  fData_RD,
  input  logic        RdDataValid,
  input  logic        WrDataReady,
  input  logic        cmdFinished
);

`ifdef FLASH_PROG_ERASE_EN
  localparam prog_state_t FIRST_STATE = S_WREN_A;
`else
  localparam prog_state_t FIRST_STATE = S_WREN_B;
`endif
  // GAP is entered on the release edge, so it lasts CS_HIGH_CYCLES-1 edges
  // and the following command state pulls the enable low on the next edge.
  localparam logic [15:0] GAP_LAST  = 16'(CS_HIGH_CYCLES - 2);
  localparam logic [31:0] POLL_LAST = 32'(MAX_POLLS - 1);

  prog_state_t state, after_gap;
  logic [23:0] addr_q;
  logic [8:0]  len, fill_count, fin_count;
  logic [7:0]  pp_idx;
  logic [15:0] gap_count;
  logic [31:0] poll_count;
  logic        wdr_q, full_q, accept;
  logic [9:0]  end_sum;
  logic        status_unused;

  // Status is only read on the cmdFinished edge; upper bits and the read
  // strobe carry nothing this sequencer needs.
  assign status_unused = ^{fData_RD[7:1], RdDataValid};

  assign wrReady = busy && (fill_count < len);
  assign accept  = wrValid && wrReady;
  assign end_sum = {2'b00, startAddr[7:0]} + {1'b0, startLen};

  flash_page_buffer u_buffer (
    .clk   (serialClk),
    .rst   (rst),
    .we    (accept),
    .waddr (fill_count[7:0]),
    .wdata (wrData),
    .raddr (pp_idx),
    .rdata (fData_WR)
  );

  // Sequencer FSM together with fill/finish/poll/gap counters and the
  // registered outputs towards the SPI interface
  always_ff @(posedge serialClk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      after_gap         <= S_IDLE;
      interfaceEnable_n <= 1'b1;
      fCommand          <= 8'h00;
      fAddress          <= 24'h0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      addr_q            <= 24'h0;
      len               <= 9'd0;
      fill_count        <= 9'd0;
      fin_count         <= 9'd0;
      pp_idx            <= 8'd0;
      gap_count         <= 16'd0;
      poll_count        <= 32'd0;
      wdr_q             <= 1'b0;
      full_q            <= 1'b0;
    end else begin
      done   <= 1'b0;
      error  <= 1'b0;
      wdr_q  <= WrDataReady;
      // One-cycle delayed "page full" so byte 0 has been read out of the
      // buffer before PP is enabled
      full_q <= (fill_count == len);
      if (accept) fill_count <= fill_count + 9'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (startLen == 9'd0 || end_sum > 10'd256) begin
              error <= 1'b1;
            end else begin
              addr_q     <= startAddr;
              len        <= startLen;
              fill_count <= 9'd0;
              pp_idx     <= 8'd0;
              busy       <= 1'b1;
              state      <= FIRST_STATE;
            end
          end
        end
`ifdef FLASH_PROG_ERASE_EN
        S_WREN_A: begin
          if (interfaceEnable_n) begin
            interfaceEnable_n <= 1'b0;
            fCommand          <= CMD_WREN;
            fAddress          <= 24'h0;
          end else if (cmdFinished) begin
            interfaceEnable_n <= 1'b1;
            gap_count         <= 16'd0;
            after_gap         <= S_PE;
            state             <= S_GAP;
          end
        end
        S_PE: begin
          if (interfaceEnable_n) begin
            interfaceEnable_n <= 1'b0;
            fCommand          <= CMD_PE;
            fAddress          <= {addr_q[23:8], 8'h00};
          end else if (cmdFinished) begin
            interfaceEnable_n <= 1'b1;
            poll_count        <= 32'd0;
            gap_count         <= 16'd0;
            after_gap         <= S_POLL_E;
            state             <= S_GAP;
          end
        end
`endif
        S_WREN_B: begin
          if (interfaceEnable_n) begin
            interfaceEnable_n <= 1'b0;
            fCommand          <= CMD_WREN;
            fAddress          <= 24'h0;
          end else if (cmdFinished) begin
            interfaceEnable_n <= 1'b1;
            gap_count         <= 16'd0;
            after_gap         <= S_PP_WAIT;
            state             <= S_GAP;
          end
        end
        S_PP_WAIT: begin
          if (full_q) begin
            interfaceEnable_n <= 1'b0;
            fCommand          <= CMD_PP;
            fAddress          <= addr_q;
            fin_count         <= 9'd0;
            state             <= S_PP;
          end
        end
        S_PP: begin
          if (WrDataReady && !wdr_q) pp_idx <= pp_idx + 8'd1;
          if (cmdFinished) begin
            if (fin_count == len - 9'd1) begin
              interfaceEnable_n <= 1'b1;
              poll_count        <= 32'd0;
              gap_count         <= 16'd0;
              after_gap         <= S_POLL_P;
              state             <= S_GAP;
            end else begin
              fin_count <= fin_count + 9'd1;
            end
          end
        end
`ifdef FLASH_PROG_ERASE_EN
        S_POLL_E, S_POLL_P: begin
`else
        S_POLL_P: begin
`endif
          if (interfaceEnable_n) begin
            interfaceEnable_n <= 1'b0;
            fCommand          <= CMD_RDSR;
            fAddress          <= 24'h0;
          end else if (cmdFinished) begin
            interfaceEnable_n <= 1'b1;
            gap_count         <= 16'd0;
            if (!fData_RD[WIP_BIT]) begin
              if (state == S_POLL_P) after_gap <= S_DONE;
              else                   after_gap <= S_WREN_B;
              state <= S_GAP;
            end else if (poll_count == POLL_LAST) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              poll_count <= poll_count + 32'd1;
              after_gap  <= state;
              state      <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_count == GAP_LAST) state <= after_gap;
          else                       gap_count <= gap_count + 16'd1;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flash_page_programmer.sv
// ============================================================================
//  Module      : tb_flash_page_programmer
//  Description : Directed self-checking bench with a behavioural SPI flash
//                interface model. Honours FLASH_PROG_ERASE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_page_programmer;

  localparam int CS = 4;

  logic        serialClk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] startAddr = 24'h0;
  logic [8:0]  startLen = 9'd0;
  logic [7:0]  wrData = 8'h00;
  logic        wrValid = 1'b0;
  logic        wrReady, busy, done, error, interfaceEnable_n;
  logic [7:0]  fCommand, fData_WR;
  logic [23:0] fAddress;
  logic [7:0]  fData_RD = 8'h00;
  logic        RdDataValid = 1'b0;
  logic        WrDataReady = 1'b0;
  logic        cmdFinished = 1'b0;

  flash_page_programmer #(.CS_HIGH_CYCLES(CS), .MAX_POLLS(8)) dut (
    .serialClk(serialClk), .rst(rst), .start(start), .startAddr(startAddr),
    .startLen(startLen), .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
    .busy(busy), .done(done), .error(error),
    .interfaceEnable_n(interfaceEnable_n), .fCommand(fCommand),
    .fAddress(fAddress), .fData_WR(fData_WR), .fData_RD(fData_RD),
    .RdDataValid(RdDataValid), .WrDataReady(WrDataReady),
    .cmdFinished(cmdFinished)
  );

  always #5 serialClk = ~serialClk;

  int cyc = 0;
  always @(posedge serialClk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  // ---------------- flash interface model (driven on negedge) --------------
  int          busy_polls = 0;
  bit          hold_wip = 1'b0;
  logic [7:0]  log_cmd [0:255];
  int          log_cyc [0:255];
  int          log_n = 0;
  logic [7:0]  pp_cap [0:255];
  logic [23:0] pp_addr_seen = 24'h0;
  logic [23:0] pe_addr_seen = 24'h0;
  int          pp_fin_n = 0, pp_act_cyc = 0;
  int          m_cnt = 0, m_byte = 0, rdsr_idx = 0, high_run = 0, gap_err = 0;
  bit          m_active = 1'b0, prev_seen = 1'b0;
  logic [7:0]  m_cmd = 8'h00;
  int          done_n = 0, err_n = 0, both_n = 0;

  always @(negedge serialClk) begin
    cmdFinished = 1'b0;
    WrDataReady = 1'b0;
    if (done) done_n++;
    if (error) err_n++;
    if (done && error) both_n++;
    if (!busy) prev_seen = 1'b0;
    if (interfaceEnable_n) begin
      m_active = 1'b0;
      high_run++;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_cmd    = fCommand;
      m_cnt    = 0;
      if (prev_seen && ((fCommand == 8'h02) ? (high_run < CS) : (high_run != CS)))
        gap_err++;
      prev_seen = 1'b1;
      high_run  = 0;
      log_cmd[log_n % 256] = fCommand;
      log_cyc[log_n % 256] = cyc;
      log_n++;
      if (fCommand == 8'h05) begin
        fData_RD = (hold_wip || rdsr_idx < busy_polls) ? 8'h01 : 8'h00;
        rdsr_idx++;
      end else begin
        rdsr_idx = 0;
      end
      if (fCommand == 8'h81) pe_addr_seen = fAddress;
      if (fCommand == 8'h02) begin
        pp_addr_seen = fAddress;
        m_byte       = 0;
        pp_fin_n     = 0;
        pp_act_cyc   = cyc;
      end
    end else begin
      m_cnt++;
      if (m_cmd != 8'h02) begin
        if (m_cnt == 3) cmdFinished = 1'b1;
      end else begin
        if (m_cnt == 2) pp_cap[m_byte % 256] = fData_WR;
        if (m_cnt == 3) begin cmdFinished = 1'b1; pp_fin_n++; end
        if (m_cnt == 4) begin m_byte++; WrDataReady = 1'b1; end
        if (m_cnt == 7) m_cnt = 1;
      end
    end
  end

  // ---------------- stimulus helpers (no comparisons) ----------------------
  int t_start = 0, last_acc_cyc = 0, fed = 0;

  task automatic do_start(input logic [23:0] a, input logic [8:0] l);
    @(negedge serialClk);
    startAddr = a; startLen = l; start = 1'b1;
    @(negedge serialClk);
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic feed(input int n, input int seed, input int spacing);
    int k = 0, wait_c = 0, guard = 0;
    while (k < n && guard < 20000) begin
      @(negedge serialClk);
      guard++;
      wrValid = 1'b0;
      if (wait_c > 0) wait_c--;
      else if (wrReady) begin
        wrData = 8'(seed + k); wrValid = 1'b1; k++;
        last_acc_cyc = cyc; wait_c = spacing - 1;
      end
    end
    @(negedge serialClk);
    wrValid = 1'b0;
    fed = k;
  endtask

  task automatic wait_idle(input int limit, output bit to);
    int n = 0;
    to = 1'b1;
    while (n < limit) begin
      @(negedge serialClk);
      n++;
      if (!busy) begin to = 1'b0; break; end
    end
    repeat (3) @(negedge serialClk);
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge serialClk);
    n_checks++; if (interfaceEnable_n !== 1'b1) $display("FAIL rst_en_n: got %b want 1", interfaceEnable_n); else n_pass++;
    n_checks++; if (fCommand !== 8'h00) $display("FAIL rst_cmd: got %h want 00", fCommand); else n_pass++;
    n_checks++; if (fAddress !== 24'h0) $display("FAIL rst_addr: got %h want 000000", fAddress); else n_pass++;
    n_checks++; if (fData_WR !== 8'h00) $display("FAIL rst_wdata: got %h want 00", fData_WR); else n_pass++;
    n_checks++; if (wrReady !== 1'b0) $display("FAIL rst_wrready: got %b want 0", wrReady); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if ({done, error} !== 2'b00) $display("FAIL rst_done_err: got %b want 00", {done, error}); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge serialClk);
  endtask

  task automatic test_full_page(input int seed);
    logic [7:0] expq[$];
    int base, d0, e0, g0, bad, fb;
    bit to;
    base = log_n; d0 = done_n; e0 = err_n; g0 = gap_err;
    busy_polls = 3;
`ifdef FLASH_PROG_ERASE_EN
    expq = '{8'h06, 8'h81, 8'h05, 8'h05, 8'h05, 8'h05};
`endif
    expq.push_back(8'h06); expq.push_back(8'h02);
    repeat (4) expq.push_back(8'h05);
    do_start(24'h012300, 9'd256);
    n_checks++; if ({busy, wrReady, interfaceEnable_n} !== 3'b111) $display("FAIL full_latency: busy/wrReady/en_n got %b want 111", {busy, wrReady, interfaceEnable_n}); else n_pass++;
    feed(256, seed, 1);
    wait_idle(6000, to);
    n_checks++; if (to !== 1'b0) $display("FAIL full_timeout: busy still %b", busy); else n_pass++;
    n_checks++; if (log_cyc[base % 256] !== t_start + 1) $display("FAIL full_first_enable: cycle %0d want %0d", log_cyc[base % 256], t_start + 1); else n_pass++;
    n_checks++; if (log_n - base !== expq.size()) $display("FAIL full_cmd_count: got %0d want %0d", log_n - base, expq.size()); else n_pass++;
    for (int i = 0; i < expq.size(); i++) begin
      n_checks++;
      if (log_cmd[(base + i) % 256] !== expq[i]) $display("FAIL full_cmd_%0d: got %h want %h", i, log_cmd[(base + i) % 256], expq[i]);
      else n_pass++;
    end
`ifdef FLASH_PROG_ERASE_EN
    n_checks++; if (pe_addr_seen !== 24'h012300) $display("FAIL full_pe_addr: got %h want 012300", pe_addr_seen); else n_pass++;
`endif
    n_checks++; if (pp_addr_seen !== 24'h012300) $display("FAIL full_pp_addr: got %h want 012300", pp_addr_seen); else n_pass++;
    bad = 0; fb = 0;
    for (int i = 0; i < 256; i++) if (pp_cap[i] !== 8'(seed + i)) begin if (bad == 0) fb = i; bad++; end
    n_checks++; if (bad !== 0) $display("FAIL full_bytes: %0d wrong, first idx %0d got %h want %h", bad, fb, pp_cap[fb], 8'(seed + fb)); else n_pass++;
    n_checks++; if (pp_fin_n !== 256) $display("FAIL full_pp_finishes: got %0d want 256", pp_fin_n); else n_pass++;
    n_checks++; if (done_n - d0 !== 1) $display("FAIL full_done_pulses: got %0d want 1", done_n - d0); else n_pass++;
    n_checks++; if (err_n - e0 !== 0) $display("FAIL full_error_pulses: got %0d want 0", err_n - e0); else n_pass++;
    n_checks++; if (gap_err - g0 !== 0) $display("FAIL full_cs_gap: %0d spacing violations want 0", gap_err - g0); else n_pass++;
  endtask

  task automatic test_partial_page();
    int d0, bad, fb;
    bit to;
    d0 = done_n; busy_polls = 1;
    do_start(24'h0000F0, 9'd16);
    feed(16, 8'hA0, 1);
    n_checks++; if (wrReady !== 1'b0) $display("FAIL part_wrready_after_fill: got %b want 0", wrReady); else n_pass++;
    wait_idle(3000, to);
    n_checks++; if (to !== 1'b0) $display("FAIL part_timeout: busy still %b", busy); else n_pass++;
    n_checks++; if (pp_addr_seen !== 24'h0000F0) $display("FAIL part_pp_addr: got %h want 0000f0", pp_addr_seen); else n_pass++;
    n_checks++; if (pp_fin_n !== 16) $display("FAIL part_pp_finishes: got %0d want 16", pp_fin_n); else n_pass++;
    bad = 0; fb = 0;
    for (int i = 0; i < 16; i++) if (pp_cap[i] !== 8'(8'hA0 + i)) begin if (bad == 0) fb = i; bad++; end
    n_checks++; if (bad !== 0) $display("FAIL part_bytes: %0d wrong, first idx %0d got %h want %h", bad, fb, pp_cap[fb], 8'(8'hA0 + fb)); else n_pass++;
    n_checks++; if (done_n - d0 !== 1) $display("FAIL part_done_pulses: got %0d want 1", done_n - d0); else n_pass++;
  endtask

  task automatic test_bad_start();
    int base, stuck;
    base = log_n;
    do_start(24'h0000F1, 9'd16);
    n_checks++; if ({error, busy, interfaceEnable_n, wrReady} !== 4'b1010) $display("FAIL bad_addr: err/busy/en_n/wrReady got %b want 1010", {error, busy, interfaceEnable_n, wrReady}); else n_pass++;
    @(negedge serialClk);
    n_checks++; if (error !== 1'b0) $display("FAIL bad_err_width: error got %b want 0", error); else n_pass++;
    do_start(24'h000000, 9'd0);
    n_checks++; if ({error, busy} !== 2'b10) $display("FAIL bad_len0: err/busy got %b want 10", {error, busy}); else n_pass++;
    stuck = 0;
    repeat (10) begin @(negedge serialClk); if (interfaceEnable_n !== 1'b1 || busy !== 1'b0) stuck++; end
    n_checks++; if (stuck !== 0) $display("FAIL bad_idle: %0d cycles active want 0", stuck); else n_pass++;
    n_checks++; if (log_n - base !== 0) $display("FAIL bad_cmds: %0d commands issued want 0", log_n - base); else n_pass++;
  endtask

  task automatic test_slow_fill();
    int d0, g0, bad, fb;
    bit to;
    d0 = done_n; g0 = gap_err; busy_polls = 0;
    do_start(24'h000500, 9'd256);
    feed(256, 8'h5C, 50);
    n_checks++; if (fed !== 256) $display("FAIL slow_fed: got %0d want 256", fed); else n_pass++;
    wait_idle(6000, to);
    n_checks++; if (to !== 1'b0) $display("FAIL slow_timeout: busy still %b", busy); else n_pass++;
    n_checks++; if (pp_act_cyc <= last_acc_cyc) $display("FAIL slow_pp_early: PP at %0d last accept at %0d", pp_act_cyc, last_acc_cyc); else n_pass++;
    bad = 0; fb = 0;
    for (int i = 0; i < 256; i++) if (pp_cap[i] !== 8'(8'h5C + i)) begin if (bad == 0) fb = i; bad++; end
    n_checks++; if (bad !== 0) $display("FAIL slow_bytes: %0d wrong, first idx %0d got %h want %h", bad, fb, pp_cap[fb], 8'(8'h5C + fb)); else n_pass++;
    n_checks++; if (done_n - d0 !== 1) $display("FAIL slow_done_pulses: got %0d want 1", done_n - d0); else n_pass++;
    n_checks++; if (gap_err - g0 !== 0) $display("FAIL slow_cs_gap: %0d violations want 0", gap_err - g0); else n_pass++;
  endtask

  task automatic test_timeout();
    int base, d0, e0, rdsr;
    bit to;
    base = log_n; d0 = done_n; e0 = err_n;
    hold_wip = 1'b1;
    do_start(24'h000100, 9'd1);
    feed(1, 8'h77, 1);
    wait_idle(3000, to);
    hold_wip = 1'b0;
    n_checks++; if (to !== 1'b0) $display("FAIL tmo_hang: busy still %b", busy); else n_pass++;
    rdsr = 0;
    for (int i = base; i < log_n; i++) if (log_cmd[i % 256] == 8'h05) rdsr++;
    n_checks++; if (rdsr !== 8) $display("FAIL tmo_rdsr_count: got %0d want 8", rdsr); else n_pass++;
    n_checks++; if (err_n - e0 !== 1) $display("FAIL tmo_error_pulses: got %0d want 1", err_n - e0); else n_pass++;
    n_checks++; if (done_n - d0 !== 0) $display("FAIL tmo_done_pulses: got %0d want 0", done_n - d0); else n_pass++;
    n_checks++; if ({busy, interfaceEnable_n} !== 2'b01) $display("FAIL tmo_idle: busy/en_n got %b want 01", {busy, interfaceEnable_n}); else n_pass++;
  endtask

  task automatic test_reset_mid_pp();
    int n;
    bit hit;
    busy_polls = 0;
    do_start(24'h012300, 9'd256);
    feed(256, 8'h11, 1);
    hit = 1'b0; n = 0;
    while (n < 6000 && !hit) begin
      @(negedge serialClk); n++;
      if (m_active && m_cmd == 8'h02 && m_byte == 100) hit = 1'b1;
    end
    n_checks++; if (hit !== 1'b1) $display("FAIL rpp_reach_byte100: got %b want 1", hit); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({interfaceEnable_n, busy, wrReady} !== 3'b100) $display("FAIL rpp_async: en_n/busy/wrReady got %b want 100", {interfaceEnable_n, busy, wrReady}); else n_pass++;
    repeat (2) @(negedge serialClk);
    rst = 1'b0;
    repeat (2) @(negedge serialClk);
    test_full_page(8'hC3);
  endtask

  initial begin
    test_reset();
    test_full_page(0);
    test_partial_page();
    test_bad_start();
    test_slow_fill();
    test_timeout();
    test_reset_mid_pp();
    n_checks++; if (both_n !== 0) $display("FAIL done_with_error: %0d overlapping cycles want 0", both_n); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
